// File: rtl/alu_iter_sequencer_pkg.sv
// Shared constants for the iterative ALU sequencer and the ALU control decoder.
// Holds the ALU control codes, the fun3 operation codes and the sequencer state type.
package alu_iter_sequencer_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_iter_sequencer.sv
// Multi-cycle MUL / DIVU / REMU sequencer that borrows the shared ALU for WIDTH
// cycles (shift-add multiply, restoring divide) and returns a registered result.
module alu_iter_sequencer
    import alu_iter_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       fun3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [2:0]         fun3_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   d_r;
    logic [CNT_W-1:0]   count_r;
    logic [WIDTH-1:0]   result_r;
    logic               done_r;
    logic [WIDTH-1:0]   rs_s;
    logic               sub_s;
    logic               is_div_s;
    logic               last_s;
    logic [3:0]         alu_ctrl_s;
    logic [WIDTH-1:0]   alu_a_s;
    logic [WIDTH-1:0]   alu_b_s;

    // Restoring-divide step: a set remainder MSB means the shifted value exceeds any divisor.
    assign rs_s     = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
    assign sub_s    = rem_r[WIDTH-1] | (rs_s >= d_r);
    assign is_div_s = (fun3 == F3_DIVU) || (fun3 == F3_REMU);
    assign last_s   = (count_r == CNT_W'(WIDTH-1));

    assign busy     = (state_r != ST_IDLE);
    assign done     = done_r;
    assign result   = result_r;
    assign alu_ctrl = alu_ctrl_s;
    assign alu_a    = alu_a_s;
    assign alu_b    = alu_b_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and ALU control/operand drive.
    always_comb begin
        state_nxt_s = state_r;
        alu_ctrl_s  = ALU_ADD;
        alu_a_s     = {WIDTH{1'b0}};
        alu_b_s     = {WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (fun3 == F3_MUL) begin
                        state_nxt_s = ST_RUN;
                    end else if (is_div_s) begin
                        state_nxt_s = (op_b == {WIDTH{1'b0}}) ? ST_DONE : ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fun3_r == F3_MUL) begin
                    alu_ctrl_s = ALU_ADD;
                    alu_a_s    = acc_r;
                    alu_b_s    = mplier_r[0] ? mcand_r : {WIDTH{1'b0}};
                end else begin
                    alu_ctrl_s = ALU_SUB;
                    alu_a_s    = rs_s;
                    alu_b_s    = sub_s ? d_r : {WIDTH{1'b0}};
                end
                state_nxt_s = last_s ? ST_DONE : ST_RUN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand capture, per-iteration accumulation and result/done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fun3_r   <= 3'b000;
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            d_r      <= {WIDTH{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
            done_r   <= 1'b0;
        end else begin
            done_r <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        fun3_r   <= fun3;
                        acc_r    <= {WIDTH{1'b0}};
                        mcand_r  <= op_a;
                        mplier_r <= op_b;
                        d_r      <= op_b;
                        count_r  <= {CNT_W{1'b0}};
                        // Divide-by-zero preloads the architected results and skips RUN.
                        if (is_div_s && (op_b == {WIDTH{1'b0}})) begin
                            quo_r <= {WIDTH{1'b1}};
                            rem_r <= op_a;
                        end else begin
                            quo_r <= op_a;
                            rem_r <= {WIDTH{1'b0}};
                        end
                    end
                end
                ST_RUN: begin
                    count_r <= count_r + CNT_W'(1);
                    if (fun3_r == F3_MUL) begin
                        acc_r    <= alu_result;
                        mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    end else begin
                        rem_r <= alu_result;
                        quo_r <= {quo_r[WIDTH-2:0], sub_s};
                    end
                end
                ST_DONE: begin
                    case (fun3_r)
                        F3_MUL:  result_r <= acc_r;
                        F3_DIVU: result_r <= quo_r;
                        F3_REMU: result_r <= rem_r;
                        default: result_r <= {WIDTH{1'b0}};
                    endcase
                end
                default: count_r <= {CNT_W{1'b0}};
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter_sequencer.sv
// Self-checking bench for alu_iter_sequencer: directed vector table, hand-written
// busy/reset corner sequences and randomized operations against an arithmetic model.
module tb_alu_iter_sequencer;
    import alu_iter_sequencer_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   fun3 = 3'b000;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;

    int checks = 0;
    int errors = 0;

    alu_iter_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fun3(fun3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Shared ALU model.
    always_comb begin
        case (alu_ctrl)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [2:0] f, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (f)
            F3_MUL:  return p[W-1:0];
            F3_DIVU: return (b == 0) ? {W{1'b1}} : a / b;
            F3_REMU: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [W-1:0] b);
        if (f == F3_MUL) return W + 1;
        if ((f == F3_DIVU || f == F3_REMU) && b != 0) return W + 1;
        return 1;
    endfunction

    // mode 1 re-asserts start with different operands in the middle of RUN.
    task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int elat,
                          input int mode);
        int lat;
        logic [3:0] exp_ctrl;
        logic ctrl_ok;
        exp_ctrl = (f == F3_MUL) ? ALU_ADD : ALU_SUB;
        ctrl_ok = 1'b1;
        @(negedge clk);
        fun3 = f; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (elat == W + 1 && lat < W && (alu_ctrl !== exp_ctrl || busy !== 1'b1))
                ctrl_ok = 1'b0;
            if (mode == 1 && lat == 5) begin
                fun3 = F3_DIVU; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({name, " latency"}, W'(lat), W'(elat));
        chk({name, " result"}, result, exp);
        chk({name, " run ctrl/busy"}, {{(W-1){1'b0}}, ctrl_ok}, 32'd1);
        @(posedge clk); #1;
        chk({name, " done width"}, {{(W-1){1'b0}}, done}, 32'd0);
        chk({name, " result hold"}, result, exp);
    endtask

    initial begin
        logic seen_done;
        logic [2:0] f;
        logic [W-1:0] a, b;
        int sel;

        tbl[0] = '{F3_MUL,  32'd7,          32'd6,       32'd42,         33};
        tbl[1] = '{F3_MUL,  32'hFFFF_FFFF,  32'd2,       32'hFFFF_FFFE,  33};
        tbl[2] = '{F3_MUL,  32'h0001_0000,  32'h0001_0000, 32'd0,        33};
        tbl[3] = '{F3_DIVU, 32'd100,        32'd7,       32'd14,         33};
        tbl[4] = '{F3_REMU, 32'd100,        32'd7,       32'd2,          33};
        tbl[5] = '{F3_DIVU, 32'hFFFF_FFFF,  32'd1,       32'hFFFF_FFFF,  33};
        tbl[6] = '{F3_REMU, 32'hFFFF_FFFF,  32'd10,      32'd5,          33};
        tbl[7] = '{F3_DIVU, 32'd5,          32'd0,       32'hFFFF_FFFF,  1};
        tbl[8] = '{F3_REMU, 32'd5,          32'd0,       32'd5,          1};
        tbl[9] = '{3'b010,  32'd123,        32'd4,       32'd0,          1};

        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset alu_ctrl", {28'd0, alu_ctrl}, 32'd2);
        chk("reset alu_a", alu_a, 32'd0);
        chk("reset alu_b", alu_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 0);

        run_op("start during run", F3_MUL, 32'd7, 32'd6, 32'd42, 33, 1);
        run_op("start after done", F3_MUL, 32'd9, 32'd9, 32'd81, 33, 0);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        fun3 = F3_MUL; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun reset busy", {31'd0, busy}, 32'd0);
        chk("midrun reset done", {31'd0, done}, 32'd0);
        chk("midrun reset result", result, 32'd0);
        chk("midrun reset alu_ctrl", {28'd0, alu_ctrl}, 32'd2);
        chk("midrun reset alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk("no done after reset", {31'd0, seen_done}, 32'd0);
        chk("result after reset", result, 32'd0);
        run_op("mul 3x3 after reset", F3_MUL, 32'd3, 32'd3, 32'd9, 33, 0);

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 4);
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 255)) : $urandom;
            case (sel)
                0: f = F3_MUL;
                1: f = F3_DIVU;
                2: f = F3_REMU;
                3: begin
                    f = 3'($urandom_range(1, 4));
                    if (f == 3'd4) f = 3'b110;
                end
                default: begin
                    f = ($urandom_range(0, 1) == 0) ? F3_DIVU : F3_REMU;
                    b = '0;
                end
            endcase
            run_op($sformatf("rand%0d f=%0d a=%08h b=%08h", i, f, a, b), f, a, b,
                   ref_result(f, a, b), ref_lat(f, b), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
